wand_bus_tx: RTL and testbench

//  Transmitter/arbiter agent for a shared wired-AND (open-drain) single-wire bus.

---
 rtl/wand_bus_tx.sv | 127 ++++++++++++
 tb/tb_wand_bus_tx.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/wand_bus_tx.sv
// Open-drain transmitter/arbiter for a shared wired-AND single-wire bus.
// Sends one MSB-first frame as START, DATA_W data bits and STOP. Each bit is read back to detect lost arbitration.
module wand_bus_tx #(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              line_in,
  output logic              drive_low,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              arb_lost,
  output logic              stop_err,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(BIT_CYCLES / 2);
  localparam logic [BIT_W-1:0] BIT_MSB    = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [BIT_W-1:0]  bit_idx;
  logic [DATA_W-1:0] tx_bits;
  logic              lost;
  logic              line_high;
  logic              lose_now;

  // Handshake: a frame is accepted on a rising edge where tx_valid & tx_ready; tx_ready is high only in IDLE.
  assign tx_ready  = (state == IDLE);
  assign dbg_state = state;

  // Only a solid 1 counts as high; x/z on the wire read as driven low.
  assign line_high = (line_in === 1'b1);
  assign lose_now  = (state == DATA) && (cnt == CNT_SAMPLE) && tx_bits[bit_idx] && !line_high;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      tx_bits   <= '0;
      lost      <= 1'b0;
      drive_low <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rx_data   <= '0;
      arb_lost  <= 1'b0;
      stop_err  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          drive_low <= 1'b0;
          if (tx_valid) begin
            tx_bits   <= tx_data;
            rx_data   <= '0;
            arb_lost  <= 1'b0;
            stop_err  <= 1'b0;
            lost      <= 1'b0;
            busy      <= 1'b1;
            cnt       <= '0;
            drive_low <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          if (cnt == CNT_LAST) begin
            bit_idx   <= BIT_MSB;
            drive_low <= ~tx_bits[DATA_W-1];
            state     <= DATA;
          end
        end
        DATA: begin
          if (cnt == CNT_SAMPLE) begin
            rx_data[bit_idx] <= line_high;
          end
          if (lose_now) begin
            lost      <= 1'b1;
            arb_lost  <= 1'b1;
            drive_low <= 1'b0;
          end
          // The bit-boundary update comes last so it overrides the loss release above.
          // It folds in a loss detected on this same edge, which matters when the sample point is the last cycle.
          if (cnt == CNT_LAST) begin
            if (bit_idx == '0) begin
              drive_low <= 1'b0;
              state     <= STOP;
            end else begin
              bit_idx   <= bit_idx - 1'b1;
              drive_low <= ~tx_bits[bit_idx - 1'b1] & ~lost & ~lose_now;
            end
          end
        end
        STOP: begin
          drive_low <= 1'b0;
          if (cnt == CNT_SAMPLE && !line_high) begin
            stop_err <= 1'b1;
          end
          if (cnt == CNT_LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          drive_low <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wand_bus_tx.sv
// Directed bench for wand_bus_tx (DATA_W=8, BIT_CYCLES=4) on a modelled wired-AND line.
// A frame spans 41 cycles from accept. Cycle k lies in frame bit (k-1)/4, where 0 is START, 1..8 are data MSB first, and 9 is STOP.
module tb_wand_bus_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       line_in;
  logic       drive_low;
  logic       busy;
  logic       done;
  logic [7:0] rx_data;
  logic       arb_lost;
  logic       stop_err;
  logic [1:0] dbg_state;

  logic       other_low;
  logic       ovr_en;
  logic       ovr_val;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  assign line_in = ovr_en ? ovr_val : (~drive_low & ~other_low);

  wand_bus_tx #(.DATA_W(8), .BIT_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .line_in   (line_in),
    .drive_low (drive_low),
    .busy      (busy),
    .done      (done),
    .rx_data   (rx_data),
    .arb_lost  (arb_lost),
    .stop_err  (stop_err),
    .dbg_state (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Called at a negedge; returns right after the accepting rising edge.
  task automatic do_accept(input logic [7:0] d, output int waited);
    tx_data  = d;
    tx_valid = 1'b1;
    waited   = 0;
    while (tx_ready !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) check("accept_timeout", 32'(tx_ready), 32'd1);
    @(posedge clk);
  endtask

  // ovr_mode: 0 none, 1 x on data bit 7, 2 z on data bit 7, 3 line low for the whole STOP bit.
  // lose_b is the frame bit where arbitration is lost (99 = never).
  task automatic run_frame(input logic [7:0] d, input int lose_b, input int ovr_mode,
                           input bit with_other, input logic [7:0] od, input bit hold_valid,
                           input logic [7:0] exp_rx, input bit exp_lost, input bit exp_stop,
                           output int waited);
    int   b;
    logic exp_dl;
    exp_q.push_back(exp_rx);
    do_accept(d, waited);
    for (int k = 1; k <= 41; k++) begin
      @(negedge clk);
      b = (k - 1) / 4;
      if (k == 1 && !hold_valid) tx_valid = 1'b0;
      other_low = with_other && (b == 0 || (b >= 1 && b <= 8 && !od[8-b]));
      ovr_en    = ((ovr_mode == 1 || ovr_mode == 2) && b == 1) || (ovr_mode == 3 && b == 9);
      ovr_val   = (ovr_mode == 1) ? 1'bx : (ovr_mode == 2) ? 1'bz : 1'b0;
      exp_dl    = (b == 0) || (b >= 1 && b <= 8 && !d[8-b] && b < lose_b);
      check("drive_low", 32'(drive_low), 32'(exp_dl));
      check("busy", 32'(busy), 32'(k <= 40));
      check("done", 32'(done), 32'(k == 41));
      check("tx_ready", 32'(tx_ready), 32'(k == 41));
      if (k == 1)  check("state_start", 32'(dbg_state), 32'd1);
      if (k == 40) check("state_stop", 32'(dbg_state), 32'd3);
      if (k == 41) begin
        check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
        check("arb_lost", 32'(arb_lost), 32'(exp_lost));
        check("stop_err", 32'(stop_err), 32'(exp_stop));
      end
    end
    other_low = 1'b0;
    ovr_en    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w, w2, done_seen;
    rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    other_low = 1'b0; ovr_en = 1'b0; ovr_val = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_drive_low", 32'(drive_low), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_arb_lost", 32'(arb_lost), 32'd0);
    check("rst_stop_err", 32'(stop_err), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Lone agent sending 0xA5
    run_frame(8'hA5, 99, 0, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0, w);
    repeat (2) @(negedge clk);

    // Competing agent sends 0x95; we lose at data bit 5 (frame bit 3)
    run_frame(8'hA5, 3, 0, 1'b1, 8'h95, 1'b0, 8'h95, 1'b1, 1'b0, w);
    @(negedge clk);

    // x, then z, on the first released data bit reads as 0
    run_frame(8'hFF, 1, 1, 1'b0, 8'h00, 1'b0, 8'h7F, 1'b1, 1'b0, w);
    run_frame(8'hFF, 1, 2, 1'b0, 8'h00, 1'b0, 8'h7F, 1'b1, 1'b0, w);
    @(negedge clk);

    // Reset pulse during data bit 3 (frame cycles 21..24)
    do_accept(8'hA5, w);
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (k == 1) tx_valid = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_drive_low", 32'(drive_low), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_tx_ready", 32'(tx_ready), 32'd1);
    check("midrst_rx_data", 32'(rx_data), 32'd0);
    done_seen = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    check("midrst_no_done", 32'(done_seen), 32'd0);

    // tx_valid held across two frames: the second is accepted in the done cycle
    run_frame(8'h3C, 99, 0, 1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b0, w);
    run_frame(8'h3C, 99, 0, 1'b0, 8'h00, 1'b0, 8'h3C, 1'b0, 1'b0, w2);
    check("b2b_accept_wait", 32'(w2), 32'd0);
    @(negedge clk);

    // Line held low through STOP
    run_frame(8'h5A, 99, 3, 1'b0, 8'h00, 1'b0, 8'h5A, 1'b0, 1'b1, w);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
